alu_arbiter: RTL and testbench

- Shares the single nibble-serial ALU (loopOverAllNibbles) between NUM_REQ requesters, e.g. PC-increment, execute and load/store address generation.
- Arbitrates round-robin, latches the winner's operands and sequences the ALU's perm_to_count/busy handshake.
- Returns the registered result with a one-cycle done pulse to the winning requester.
- Sits between the control FSM clients and the ALU; it is the only driver of the ALU inputs.

---
 rtl/alu_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one nibble-serial ALU between NUM_REQ requesters.
// Optional macro ALU_ARB_LOCK_EN adds req_lock so that a requester can chain operations atomically.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CTRL_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
    input  logic [NUM_REQ*32-1:0] req_w1,
    input  logic [NUM_REQ*32-1:0] req_w2,
    input  logic [NUM_REQ*3-1:0]  req_nibbles,
    input  logic [NUM_REQ-1:0]    req_w2_neg,
    input  logic [NUM_REQ*32-1:0] req_preinit,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]    req_lock,
`endif
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [31:0]           rsp_result,
    output logic                  arb_busy,
    output logic                  alu_perm_to_count,
    output logic [CTRL_W-1:0]     alu_ctrl,
    output logic [31:0]           alu_w1,
    output logic [31:0]           alu_w2,
    output logic [2:0]            alu_nibbles,
    output logic                  alu_w2_neg,
    output logic [31:0]           alu_preinit,
    input  logic                  alu_busy,
    input  logic [31:0]           alu_result
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_valid;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             lock_hit;
    logic [NUM_REQ-1:0] gnt_vec;

    function automatic logic [IDX_W-1:0] rr_pos(input logic [IDX_W-1:0] base, input int k);
        int j;
        j = int'(base) + 32'sd1 + k;
        if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
        end else begin
            j = j;
        end
        return IDX_W'(j);
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search starting one past the previous winner
    always_comb begin
        rr_idx   = '0;
        rr_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_valid && req[rr_pos(last_winner, k)]) begin
                rr_valid = 1'b1;
                rr_idx   = rr_pos(last_winner, k);
            end else begin
                rr_idx   = rr_idx;
            end
        end
    end

`ifdef ALU_ARB_LOCK_EN
    logic locked;
    assign lock_hit = locked && req[cur_idx];
`else
    assign lock_hit = 1'b0;
`endif

    // Winner selection: a held lock overrides round-robin
    always_comb begin
        win_idx   = rr_idx;
        win_valid = rr_valid;
        if (lock_hit) begin
            win_idx   = cur_idx;
            win_valid = 1'b1;
        end else begin
            win_idx   = rr_idx;
            win_valid = rr_valid;
        end
    end

    // Next-state logic; gnt is decoded straight from the IDLE decision
    always_comb begin
        next_state = state;
        gnt_vec    = '0;
        case (state)
            IDLE: begin
                if (win_valid && !rst) begin
                    next_state = ISSUE;
                    gnt_vec    = idx_onehot(win_idx);
                end else begin
                    next_state = IDLE;
                end
            end
            ISSUE: next_state = RUN;
            RUN: begin
                if (!alu_busy) begin
                    next_state = RESP;
                end else begin
                    next_state = RUN;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign gnt = gnt_vec;

    // State, ALU operand latches, response and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            last_winner       <= IDX_W'(NUM_REQ - 1);
            cur_idx           <= '0;
            done              <= '0;
            rsp_result        <= 32'h0000_0000;
            arb_busy          <= 1'b0;
            alu_perm_to_count <= 1'b0;
            alu_ctrl          <= '0;
            alu_w1            <= 32'h0000_0000;
            alu_w2            <= 32'h0000_0000;
            alu_nibbles       <= 3'd0;
            alu_w2_neg        <= 1'b0;
            alu_preinit       <= 32'h0000_0000;
        end else begin
            state             <= next_state;
            arb_busy          <= (next_state != IDLE);
            alu_perm_to_count <= (next_state == ISSUE) || (next_state == RUN);
            done              <= '0;
            if (state == IDLE && win_valid) begin
                cur_idx     <= win_idx;
                alu_ctrl    <= req_ctrl[win_idx*CTRL_W +: CTRL_W];
                alu_w1      <= req_w1[win_idx*32 +: 32];
                alu_w2      <= req_w2[win_idx*32 +: 32];
                alu_nibbles <= req_nibbles[win_idx*3 +: 3];
                alu_w2_neg  <= req_w2_neg[win_idx];
                alu_preinit <= req_preinit[win_idx*32 +: 32];
                // A locked re-grant leaves the pointer where it was
                if (!lock_hit) begin
                    last_winner <= win_idx;
                end
            end
            if (state == RESP) begin
                rsp_result <= alu_result;
                done       <= idx_onehot(cur_idx);
            end
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // Lock follows the winner's req_lock at grant; dropped when IDLE sees no winner
    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
        end else if (state == IDLE) begin
            if (win_valid) begin
                locked <= req_lock[win_idx];
            end else begin
                locked <= 1'b0;
            end
        end else begin
            locked <= locked;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU.
module tb_alu_arbiter;

    localparam int NR = 2;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*CW-1:0]  req_ctrl = '0;
    logic [NR*32-1:0]  req_w1 = '0;
    logic [NR*32-1:0]  req_w2 = '0;
    logic [NR*3-1:0]   req_nibbles = '0;
    logic [NR-1:0]     req_w2_neg = '0;
    logic [NR*32-1:0]  req_preinit = '0;
`ifdef ALU_ARB_LOCK_EN
    logic [NR-1:0]     req_lock = '0;
`endif
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic [31:0]       rsp_result;
    logic              arb_busy;
    logic              alu_perm_to_count;
    logic [CW-1:0]     alu_ctrl;
    logic [31:0]       alu_w1;
    logic [31:0]       alu_w2;
    logic [2:0]        alu_nibbles;
    logic              alu_w2_neg;
    logic [31:0]       alu_preinit;
    logic              alu_busy;
    logic [31:0]       alu_result;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.NUM_REQ(NR), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ctrl(req_ctrl),
        .req_w1(req_w1), .req_w2(req_w2), .req_nibbles(req_nibbles),
        .req_w2_neg(req_w2_neg), .req_preinit(req_preinit),
`ifdef ALU_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .gnt(gnt), .done(done), .rsp_result(rsp_result), .arb_busy(arb_busy),
        .alu_perm_to_count(alu_perm_to_count), .alu_ctrl(alu_ctrl),
        .alu_w1(alu_w1), .alu_w2(alu_w2), .alu_nibbles(alu_nibbles),
        .alu_w2_neg(alu_w2_neg), .alu_preinit(alu_preinit),
        .alu_busy(alu_busy), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: busy for N cycles after perm rises, N from the nibble count
    logic [3:0] busy_cnt = 4'd0;
    logic       started  = 1'b0;
    always @(posedge clk) begin
        if (alu_perm_to_count !== 1'b1) begin
            started  <= 1'b0;
            busy_cnt <= 4'd0;
        end else if (!started) begin
            started  <= 1'b1;
            busy_cnt <= {1'b0, alu_nibbles};
        end else if (busy_cnt != 4'd0) begin
            busy_cnt <= busy_cnt - 4'd1;
        end
    end
    assign alu_busy   = (busy_cnt != 4'd0);
    assign alu_result = (alu_nibbles == 3'd0) ? alu_preinit + alu_w2 : alu_w1 + alu_w2;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] pre, input logic [2:0] nib);
        req_ctrl[i*CW +: CW]   = 4'(i + 1);
        req_w1[i*32 +: 32]     = w1;
        req_w2[i*32 +: 32]     = w2;
        req_preinit[i*32 +: 32] = pre;
        req_nibbles[i*3 +: 3]  = nib;
        req_w2_neg[i]          = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && arb_busy !== 1'b0; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        checks++;
        if (gnt !== 2'b00 || done !== 2'b00) begin
            errors++; $display("FAIL reset_pulses gnt=%b done=%b required 00 00", gnt, done);
        end
        checks++;
        if (rsp_result !== 32'h0 || arb_busy !== 1'b0 || alu_perm_to_count !== 1'b0) begin
            errors++; $display("FAIL reset_status rsp=%h busy=%b perm=%b required 0 0 0", rsp_result, arb_busy, alu_perm_to_count);
        end
        checks++;
        if (alu_w1 !== 32'h0 || alu_w2 !== 32'h0 || alu_preinit !== 32'h0 || alu_ctrl !== 4'h0 ||
            alu_nibbles !== 3'd0 || alu_w2_neg !== 1'b0) begin
            errors++; $display("FAIL reset_operands w1=%h w2=%h pre=%h required all zero", alu_w1, alu_w2, alu_preinit);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_inc();
        set_op(0, 32'h0000_0AEF, 32'h0000_0004, 32'h0000_0AEF, 3'd0);
        req = 2'b01;
        #1;
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL inc_gnt got %b required 01", gnt); end
        tick();
        req = 2'b00;
        checks++;
        if (alu_perm_to_count !== 1'b1 || arb_busy !== 1'b1 || alu_w1 !== 32'h0AEF ||
            alu_preinit !== 32'h0AEF || alu_ctrl !== 4'h1 || gnt !== 2'b00) begin
            errors++; $display("FAIL inc_issue perm=%b busy=%b w1=%h ctrl=%h gnt=%b required 1 1 aef 1 00",
                               alu_perm_to_count, arb_busy, alu_w1, alu_ctrl, gnt);
        end
        tick();
        checks++;
        if (alu_perm_to_count !== 1'b1 || done !== 2'b00) begin
            errors++; $display("FAIL inc_run perm=%b done=%b required 1 00", alu_perm_to_count, done);
        end
        tick();
        checks++;
        if (alu_perm_to_count !== 1'b0 || done !== 2'b00) begin
            errors++; $display("FAIL inc_resp perm=%b done=%b required 0 00", alu_perm_to_count, done);
        end
        tick();
        checks++;
        if (done !== 2'b01 || rsp_result !== 32'h0000_0AF3 || arb_busy !== 1'b0) begin
            errors++; $display("FAIL inc_done done=%b rsp=%h busy=%b required 01 00000af3 0", done, rsp_result, arb_busy);
        end
        tick();
        checks++;
        if (done !== 2'b00) begin errors++; $display("FAIL inc_done_width done=%b required 00", done); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0]   exp_r [4] = '{32'd128, 32'd125, 32'd128, 32'd125};
        int gi = 0;
        int di = 0;
        bit dropped = 1'b0;
        rst = 1'b1;
        set_op(0, 32'd5, 32'd123, 32'd0, 3'd2);
        set_op(1, 32'd123, 32'd2, 32'd0, 3'd2);
        req = 2'b11;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 80 && di < 4; cyc++) begin
            #1;
            if ($countones(gnt) > 1) begin
                checks++; errors++; $display("FAIL rr_onehot gnt=%b required at most one bit", gnt);
            end
            if (gnt !== 2'b00) begin
                checks++;
                if (gi >= 4) begin
                    errors++; $display("FAIL rr_extra_grant gnt=%b required none", gnt);
                end else if (gnt !== exp_g[gi]) begin
                    errors++; $display("FAIL rr_order grant %0d got %b required %b", gi, gnt, exp_g[gi]);
                end
                gi++;
            end
            if (done !== 2'b00) begin
                checks++;
                if (di < 4 && (done !== exp_g[di] || rsp_result !== exp_r[di])) begin
                    errors++; $display("FAIL rr_result op %0d done=%b rsp=%0d required %b %0d",
                                       di, done, rsp_result, exp_g[di], exp_r[di]);
                end
                di++;
            end
            if (gi == 4 && !dropped && gnt === 2'b00) begin
                req = 2'b00;
                dropped = 1'b1;
            end
            tick();
        end
        checks++;
        if (di != 4 || gi != 4) begin
            errors++; $display("FAIL rr_timeout grants=%0d dones=%0d required 4 4", gi, di);
        end
        req = 2'b00;
        wait_idle();
    endtask

    task automatic test_long_busy();
        set_op(0, 32'h1111_1111, 32'h2222_2222, 32'h0, 3'd7);
        req = 2'b01;
        #1;
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL long_gnt got %b required 01", gnt); end
        tick();
        req = 2'b00;
        set_op(0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 3'd1);
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if (alu_perm_to_count !== 1'b1 || alu_w1 !== 32'h1111_1111 || alu_w2 !== 32'h2222_2222 ||
                alu_nibbles !== 3'd7 || done !== 2'b00) begin
                errors++; $display("FAIL long_run cycle %0d perm=%b w1=%h w2=%h done=%b required 1 11111111 22222222 00",
                                   c, alu_perm_to_count, alu_w1, alu_w2, done);
            end
            tick();
        end
        checks++;
        if (alu_perm_to_count !== 1'b0 || done !== 2'b00) begin
            errors++; $display("FAIL long_resp perm=%b done=%b required 0 00", alu_perm_to_count, done);
        end
        tick();
        checks++;
        if (done !== 2'b01 || rsp_result !== 32'h3333_3333) begin
            errors++; $display("FAIL long_done done=%b rsp=%h required 01 33333333", done, rsp_result);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_run();
        int stray = 0;
        set_op(0, 32'h0000_0100, 32'h0000_0200, 32'h0, 3'd7);
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (alu_perm_to_count !== 1'b0 || arb_busy !== 1'b0 || done !== 2'b00 || rsp_result !== 32'h0) begin
            errors++; $display("FAIL midrst_state perm=%b busy=%b done=%b rsp=%h required 0 0 00 0",
                               alu_perm_to_count, arb_busy, done, rsp_result);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done !== 2'b00 || gnt !== 2'b00) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midrst_stray got %0d stray cycles required 0", stray); end
        set_op(0, 32'h0, 32'd1, 32'd9, 3'd0);
        req = 2'b01;
        #1;
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL midrst_regnt got %b required 01", gnt); end
        tick();
        req = 2'b00;
        tick();
        tick();
        tick();
        checks++;
        if (done !== 2'b01 || rsp_result !== 32'd10) begin
            errors++; $display("FAIL midrst_done done=%b rsp=%0d required 01 10", done, rsp_result);
        end
        wait_idle();
    endtask

    task automatic test_withdraw();
        int stray = 0;
        int done0 = 0;
        set_op(0, 32'h0, 32'd2, 32'd5, 3'd0);
        set_op(1, 32'h0, 32'd1, 32'd100, 3'd0);
        req = 2'b01;
        #1;
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL wd_gnt0 got %b required 01", gnt); end
        tick();
        req = 2'b11;
        tick();
        req = 2'b01;
        tick();
        tick();
        #1;
        checks++;
        if (done !== 2'b01 || rsp_result !== 32'd7 || gnt !== 2'b01) begin
            errors++; $display("FAIL wd_regrant done=%b rsp=%0d gnt=%b required 01 7 01", done, rsp_result, gnt);
        end
        tick();
        req = 2'b00;
        for (int c = 0; c < 10; c++) begin
            if (gnt[1] !== 1'b0 || done[1] !== 1'b0) stray++;
            if (done[0] === 1'b1) done0++;
            tick();
        end
        checks++;
        if (stray != 0 || done0 != 1) begin
            errors++; $display("FAIL wd_stray got stray=%0d done0=%0d required 0 1", stray, done0);
        end
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        logic [NR-1:0] exp_g [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
        int gi = 0;
        bit dropped = 1'b0;
        rst = 1'b1;
        set_op(0, 32'd1, 32'd1, 32'd0, 3'd1);
        set_op(1, 32'd2, 32'd2, 32'd0, 3'd1);
        req_lock = 2'b10;
        req = 2'b10;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 80 && gi < 4; cyc++) begin
            #1;
            if (gnt !== 2'b00) begin
                checks++;
                if (gnt !== exp_g[gi]) begin
                    errors++; $display("FAIL lock_order grant %0d got %b required %b", gi, gnt, exp_g[gi]);
                end
                gi++;
                if (gi == 1) req[0] = 1'b1;
            end else if (gi == 3 && !dropped) begin
                req[1] = 1'b0;
                dropped = 1'b1;
            end
            tick();
        end
        checks++;
        if (gi != 4) begin errors++; $display("FAIL lock_timeout grants=%0d required 4", gi); end
        req = 2'b00;
        req_lock = 2'b00;
        tick();
        wait_idle();
    endtask
`endif

    initial begin
        tick();
        test_reset();
        test_single_inc();
        wait_idle();
        test_round_robin();
        test_long_busy();
        test_reset_mid_run();
        test_withdraw();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
